// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer feeding the gauss-to-sobel line buffer.
// Optional stall/frame statistics: define SOBEL_CTRL_STATS_EN.
module sobel_frame_ctrl #(
   parameter int WIDTH    = 508,
   parameter int HEIGHT   = 508,
   parameter int R_KERNEL = 1,
   parameter int CNT_W    = 10,
   parameter int OCNT_W   = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_pixel,
   output logic              s_ready,
   output logic              buf_write,
   output logic [7:0]        buf_pixel,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OCNT_W-1:0] out_count,
`ifdef SOBEL_CTRL_STATS_EN
   output logic [31:0]       stall_cycles,
   output logic [15:0]       frame_cnt,
`endif
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);
   localparam logic [CNT_W-1:0] EDGE     = CNT_W'(2 * R_KERNEL);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [CNT_W-1:0]  col_q, col_d;
   logic [OCNT_W-1:0] out_count_q, out_count_d;
   logic              buf_write_q, buf_write_d;
   logic [7:0]        buf_pixel_q, buf_pixel_d;
   logic              m_valid_q, m_valid_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
`ifdef SOBEL_CTRL_STATS_EN
   logic [31:0]       stall_q, stall_d;
   logic [15:0]       fcnt_q, fcnt_d;
`endif

   logic acc;
   logic interior;
   logic last_col;
   logic last_row;
   logic consume;

   // Ready drops while a result waits, so the window never shifts under it.
   assign s_ready  = (state_q == STREAM) && (!m_valid_q || m_ready);
   assign acc      = s_valid && s_ready;
   assign interior = (row_q >= EDGE) && (col_q >= EDGE);
   assign last_col = (col_q == LAST_COL);
   assign last_row = (row_q == LAST_ROW);
   assign consume  = m_valid_q && m_ready;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      out_count_d  = out_count_q;
      buf_write_d  = 1'b0;
      buf_pixel_d  = buf_pixel_q;
      m_valid_d    = m_valid_q;
`ifdef SOBEL_CTRL_STATS_EN
      stall_d      = stall_q;
      fcnt_d       = fcnt_q;
`endif

      if (consume) begin
         out_count_d = out_count_q + OCNT_W'(1);
      end

      if (acc && interior) begin
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end

`ifdef SOBEL_CTRL_STATS_EN
      if ((state_q == STREAM || state_q == DRAIN) && m_valid_q && !m_ready) begin
         stall_d = stall_q + 32'd1;
      end
      if (state_q == DONE) begin
         fcnt_d = fcnt_q + 16'd1;
      end
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = STREAM;
               row_d       = '0;
               col_d       = '0;
               out_count_d = '0;
`ifdef SOBEL_CTRL_STATS_EN
               stall_d     = '0;
`endif
            end
         end
         STREAM: begin
            if (acc) begin
               buf_write_d = 1'b1;
               buf_pixel_d = s_pixel;
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     row_d   = '0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + CNT_W'(1);
                  end
               end else begin
                  col_d = col_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (!m_valid_q || m_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         row_d       = '0;
         col_d       = '0;
         out_count_d = '0;
         buf_write_d = 1'b0;
         m_valid_d   = 1'b0;
      end

      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         out_count_q  <= '0;
         buf_write_q  <= 1'b0;
         buf_pixel_q  <= '0;
         m_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SOBEL_CTRL_STATS_EN
         stall_q      <= '0;
         fcnt_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         out_count_q  <= out_count_d;
         buf_write_q  <= buf_write_d;
         buf_pixel_q  <= buf_pixel_d;
         m_valid_q    <= m_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef SOBEL_CTRL_STATS_EN
         stall_q      <= stall_d;
         fcnt_q       <= fcnt_d;
`endif
      end
   end

   assign buf_write  = buf_write_q;
   assign buf_pixel  = buf_pixel_q;
   assign m_valid    = m_valid_q;
   assign out_count  = out_count_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
`ifdef SOBEL_CTRL_STATS_EN
   assign stall_cycles = stall_q;
   assign frame_cnt    = fcnt_q;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on an 8x6 frame.
// Build with SOBEL_CTRL_STATS_EN to also check the statistics ports.
module tb_sobel_frame_ctrl;

   localparam int W = 8;
   localparam int H = 6;
   localparam int NPIX = W * H;
   localparam int NRES = (W - 2) * (H - 2);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_pixel = '0;
   logic        s_ready;
   logic        buf_write;
   logic [7:0]  buf_pixel;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [19:0] out_count;
   logic        busy;
   logic        frame_done;
`ifdef SOBEL_CTRL_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] frame_cnt;
`endif

   sobel_frame_ctrl #(
      .WIDTH(W), .HEIGHT(H), .R_KERNEL(1), .CNT_W(10), .OCNT_W(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_pixel(s_pixel), .s_ready(s_ready),
      .buf_write(buf_write), .buf_pixel(buf_pixel),
      .m_valid(m_valid), .m_ready(m_ready), .out_count(out_count),
`ifdef SOBEL_CTRL_STATS_EN
      .stall_cycles(stall_cycles), .frame_cnt(frame_cnt),
`endif
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pix;
      logic       intr;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   writes = 0;
   int   results = 0;
   int   dones = 0;
   int   first_mv = -1;
   int   exp_frames = 0;
   bit   prev_stall = 1'b0;

   task automatic check(input string n, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the buffer is written.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (buf_write) begin
            writes++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("buf_pixel", buf_pixel, e.pix);
               check("m_valid_at_write", m_valid, e.intr);
            end
         end
         if (m_valid && first_mv < 0) first_mv = writes;
         if (m_valid && m_ready) results++;
         if (frame_done) dones++;
         if (m_valid && !m_ready) check("s_ready_in_stall", s_ready, 0);
         if (prev_stall) check("write_in_stall", buf_write, 0);
         prev_stall = m_valid && !m_ready;
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_buf_write"}, buf_write, 0);
      check({tag, "_buf_pixel"}, buf_pixel, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_out_count"}, out_count, 0);
   endtask

   task automatic run_frame(input bit toggle, input int stall_len,
                            input int abort_idx, input int start_idx,
                            input int rst_idx);
      int   idx;
      int   cyc;
      int   stall_left;
      bit   stall_done;
      int   k;
      exp_t e;
      idx = 0;
      cyc = 0;
      stall_left = 0;
      stall_done = 0;
      writes = 0;
      results = 0;
      dones = 0;
      first_mv = -1;
      exp_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < NPIX && cyc < 600) begin
         if (idx == abort_idx) begin
            s_valid = 1'b0;
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_m_valid", m_valid, 0);
            check("abort_buf_write", buf_write, 0);
            check("abort_out_count", out_count, 0);
            repeat (5) @(negedge clk);
            check("abort_no_done", dones, 0);
            exp_q.delete();
            return;
         end
         if (idx == rst_idx) begin
            s_valid = 1'b0;
            #3;
            rst_n = 1'b0;
            start = 1'b1;
            #1;
            check_reset_vals("async_rst");
            @(negedge clk);
            start = 1'b0;
            #2;
            rst_n = 1'b1;
            @(negedge clk);
            #1;
            check("rst_start_ignored", busy, 0);
            exp_frames = 0;
            exp_q.delete();
            return;
         end
         start = (idx == start_idx);
         if (stall_len > 0 && !stall_done && m_valid) begin
            stall_left = stall_len;
            stall_done = 1;
         end
         m_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         s_valid = toggle ? cyc[0] : 1'b1;
         s_pixel = 8'(idx * 7 + 3);
         #1;
         if (s_valid && s_ready) begin
            e.pix = s_pixel;
            e.intr = ((idx / W) >= 2) && ((idx % W) >= 2);
            exp_q.push_back(e);
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      check("pixel_timeout", idx, NPIX);
      s_valid = 1'b0;
      start = 1'b0;
      m_ready = 1'b1;
      for (k = 0; k < 30; k++) begin
         #1;
         if (!busy) break;
         @(negedge clk);
      end
      check("drain_timeout", k < 30, 1);
      exp_frames++;
      check("frame_done_pulses", dones, 1);
      check("out_count", out_count, NRES);
      check("buf_writes", writes, NPIX);
      check("results", results, NRES);
      check("first_result_at", first_mv, 19);
      check("queue_empty", exp_q.size(), 0);
`ifdef SOBEL_CTRL_STATS_EN
      check("stall_cycles", stall_cycles, stall_len);
      check("frame_cnt", frame_cnt, exp_frames);
`endif
   endtask

   initial begin
      #3;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(0, 0, -1, -1, -1);
      run_frame(0, 5, -1, -1, -1);
      run_frame(1, 0, -1, -1, -1);
      run_frame(0, 0, 26, -1, -1);
      run_frame(0, 0, -1, -1, -1);
      run_frame(0, 0, -1, 30, -1);
      run_frame(0, 0, -1, -1, 12);
      run_frame(0, 0, -1, -1, -1);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
